// File: rtl/mips150_pkg.sv
// Shared MIPS150 definitions: word width, the NOP encoding, the default squash
// depth and the IF/ID pipeline register layout.
package mips150_pkg;

  localparam int WORD_W = 32;

  // sll $0,$0,0
  localparam logic [WORD_W-1:0] NOP_INSTR = 32'h0000_0000;

  localparam int FLUSH_DEPTH_DEF = 2;

  typedef struct packed {
    logic [WORD_W-1:0] instr;
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] pc_4;
    logic              valid;
  } if_id_t;

  // 32-bit modulo increment: 32'hFFFF_FFFC wraps to 0 with no carry out.
  function automatic logic [WORD_W-1:0] pc_plus4(input logic [WORD_W-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry skid buffer for the IMEM word that arrives on the first stall cycle,
// plus the mux choosing between the held word and live IMEM data.
module fetch_skid_buf
  import mips150_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  input  logic              i_en,
  input  logic              i_flush,
  input  logic [WORD_W-1:0] i_imem_dout,
  output logic [WORD_W-1:0] o_f_instr
);

  logic              r_hold_valid;
  logic [WORD_W-1:0] r_hold_instr;
  logic              w_hold_valid_next;
  logic [WORD_W-1:0] w_hold_instr_next;

  // Next-state for the hold slot: the IMEM address keeps moving during a stall,
  // so only the first stall cycle's word is the one belonging to PC_IF.
  always_comb begin
    w_hold_valid_next = r_hold_valid;
    w_hold_instr_next = r_hold_instr;
    if (i_en || i_flush) begin
      w_hold_valid_next = 1'b0;
    end else if (!r_hold_valid) begin
      w_hold_valid_next = 1'b1;
      w_hold_instr_next = i_imem_dout;
    end else begin
      w_hold_valid_next = r_hold_valid;
      w_hold_instr_next = r_hold_instr;
    end
  end

  // Hold slot state register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_hold_valid <= 1'b0;
      r_hold_instr <= 32'h0000_0000;
    end else begin
      r_hold_valid <= w_hold_valid_next;
      r_hold_instr <= w_hold_instr_next;
    end
  end

  // Fetched-word select.
  always_comb begin
    if (r_hold_valid) begin
      o_f_instr = r_hold_instr;
    end else begin
      o_f_instr = i_imem_dout;
    end
  end

endmodule

// File: rtl/if_id_stage.sv
// MIPS150 fetch-to-decode stage: IF/ID register, stall replay and post-redirect squash.
// Build option: define IF_DELAY_SLOT_EN to let the flush-cycle word enter ID as a delay slot.
module if_id_stage
  import mips150_pkg::*;
#(
  parameter int                FLUSH_DEPTH = FLUSH_DEPTH_DEF,
  parameter logic [WORD_W-1:0] NOP_WORD    = NOP_INSTR
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              EN,
  input  logic              flush,
  input  logic [WORD_W-1:0] PC_IF,
  input  logic [WORD_W-1:0] IMEM_DOUT,
  output logic [WORD_W-1:0] PC_4,
  output logic [WORD_W-1:0] ID_INSTR,
  output logic [WORD_W-1:0] ID_PC,
  output logic [WORD_W-1:0] ID_PC_4,
  output logic              ID_VALID
);

  localparam logic [1:0] SQUASH_LOAD = 2'(FLUSH_DEPTH - 1);

  logic [WORD_W-1:0] w_f_instr;
  logic              w_squash;
  logic [1:0]        r_squash_cnt;
  logic [1:0]        w_squash_cnt_next;
  if_id_t            r_id;
  if_id_t            w_id_next;

  fetch_skid_buf u_skid (
    .CLK         (CLK),
    .RST         (RST),
    .i_en        (EN),
    .i_flush     (flush),
    .i_imem_dout (IMEM_DOUT),
    .o_f_instr   (w_f_instr)
  );

  // Squash decision for the slot loading on this edge.
  always_comb begin
`ifdef IF_DELAY_SLOT_EN
    w_squash = (r_squash_cnt != 2'd0);
`else
    w_squash = flush | (r_squash_cnt != 2'd0);
`endif
  end

  // Squash counter: a flush reload wins over the decrement; stalls freeze it.
  always_comb begin
    w_squash_cnt_next = r_squash_cnt;
    if (flush) begin
      w_squash_cnt_next = SQUASH_LOAD;
    end else if (EN && (r_squash_cnt != 2'd0)) begin
      w_squash_cnt_next = r_squash_cnt - 2'd1;
    end else begin
      w_squash_cnt_next = r_squash_cnt;
    end
  end

  // IF/ID register next-state; the PC still advances for squashed slots.
  always_comb begin
    w_id_next = r_id;
    if (EN) begin
      w_id_next.pc   = PC_IF;
      w_id_next.pc_4 = pc_plus4(PC_IF);
      if (w_squash) begin
        w_id_next.instr = NOP_WORD;
        w_id_next.valid = 1'b0;
      end else begin
        w_id_next.instr = w_f_instr;
        w_id_next.valid = 1'b1;
      end
    end else begin
      w_id_next = r_id;
    end
  end

  // Pipeline and counter state registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_id.instr   <= NOP_WORD;
      r_id.pc      <= 32'h0000_0000;
      r_id.pc_4    <= 32'h0000_0000;
      r_id.valid   <= 1'b0;
      r_squash_cnt <= 2'd0;
    end else begin
      r_id         <= w_id_next;
      r_squash_cnt <= w_squash_cnt_next;
    end
  end

  assign PC_4     = pc_plus4(PC_IF);
  assign ID_INSTR = r_id.instr;
  assign ID_PC    = r_id.pc;
  assign ID_PC_4  = r_id.pc_4;
  assign ID_VALID = r_id.valid;

endmodule

// File: tb/tb_if_id_stage.sv
// Self-checking bench for if_id_stage: directed scenarios plus randomized traffic
// against a queue-based reference model of the fetch/decode handoff.
module tb_if_id_stage;

  logic        CLK = 1'b0;
  logic        RST, EN, flush;
  logic [31:0] PC_IF, IMEM_DOUT;
  logic [31:0] PC_4, ID_INSTR, ID_PC, ID_PC_4;
  logic        ID_VALID;

  int checks = 0;
  int errors = 0;

  localparam int DEPTH = 2;
`ifdef IF_DELAY_SLOT_EN
  localparam bit DSLOT = 1'b1;
`else
  localparam bit DSLOT = 1'b0;
`endif

  // Reference model: what decode should see, the word owed from a stall, slots left to kill.
  logic [31:0] m_instr, m_pc, m_pc4;
  logic        m_valid;
  logic [31:0] m_owed[$];
  int          m_kill_left;

  always #5 CLK = ~CLK;

  if_id_stage dut (
    .CLK       (CLK),
    .RST       (RST),
    .EN        (EN),
    .flush     (flush),
    .PC_IF     (PC_IF),
    .IMEM_DOUT (IMEM_DOUT),
    .PC_4      (PC_4),
    .ID_INSTR  (ID_INSTR),
    .ID_PC     (ID_PC),
    .ID_PC_4   (ID_PC_4),
    .ID_VALID  (ID_VALID)
  );

  // Drive one cycle of inputs, take the edge, advance the model, settle 1 time unit.
  task automatic cycle(input logic rst, input logic en, input logic fl,
                       input logic [31:0] pc, input logic [31:0] dout);
    logic [31:0] word;
    bit          kill;
    @(negedge CLK);
    RST = rst; EN = en; flush = fl; PC_IF = pc; IMEM_DOUT = dout;
    @(posedge CLK);
    if (rst) begin
      m_instr = 32'h0; m_pc = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
      m_owed.delete();
      m_kill_left = 0;
    end else begin
      word = (m_owed.size() > 0) ? m_owed[0] : dout;
      kill = (fl && !DSLOT) || (m_kill_left > 0);
      if (en) begin
        m_pc    = pc;
        m_pc4   = pc + 32'd4;
        m_instr = kill ? 32'h0 : word;
        m_valid = !kill;
      end
      if (en || fl) m_owed.delete();
      else if (m_owed.size() == 0) m_owed.push_back(dout);
      if (fl) m_kill_left = DEPTH - 1;
      else if (en && m_kill_left > 0) m_kill_left--;
    end
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      cycle(1'b1, 1'b1, 1'b1, 32'h0000_0040, 32'hDEAD_BEEF);
      checks++;
      if ({ID_INSTR, ID_PC, ID_PC_4, ID_VALID} !== {32'h0, 32'h0, 32'h0, 1'b0}) begin
        errors++;
        $display("FAIL reset got %h/%h/%h/%b want 0/0/0/0", ID_INSTR, ID_PC, ID_PC_4, ID_VALID);
      end
    end
  endtask

  task automatic test_straight();
    logic [31:0] words [3];
    words[0] = 32'hAAAA_0001; words[1] = 32'hBBBB_0002; words[2] = 32'hCCCC_0003;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 32'(4 * i), words[i]);
      checks++;
      if ({ID_INSTR, ID_PC, ID_PC_4, ID_VALID} !== {words[i], 32'(4 * i), 32'(4 * i + 4), 1'b1}) begin
        errors++;
        $display("FAIL straight[%0d] got %h/%h/%h/%b want %h/%h/%h/1", i, ID_INSTR, ID_PC,
                 ID_PC_4, ID_VALID, words[i], 32'(4 * i), 32'(4 * i + 4));
      end
      checks++;
      if (PC_4 !== 32'(4 * i + 4)) begin
        errors++;
        $display("FAIL straight_pc4[%0d] got %h want %h", i, PC_4, 32'(4 * i + 4));
      end
    end
  endtask

  task automatic test_stall_replay();
    logic [31:0] junk [4];
    junk[0] = 32'hB0B0_0004; junk[1] = 32'h5858_5858; junk[2] = 32'h5959_5959; junk[3] = 32'h5A5A_5A5A;
    cycle(1'b0, 1'b1, 1'b0, 32'h0, 32'hAAAA_0001);
    // first stall cycle carries B; X, Y, Z follow while PC_IF stays at 4
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 32'h4, junk[i]);
      checks++;
      if ({ID_INSTR, ID_PC, ID_VALID} !== {32'hAAAA_0001, 32'h0, 1'b1}) begin
        errors++;
        $display("FAIL stall_hold[%0d] got %h/%h/%b want aaaa0001/0/1", i, ID_INSTR, ID_PC, ID_VALID);
      end
    end
    cycle(1'b0, 1'b1, 1'b0, 32'h4, 32'h7777_7777);
    checks++;
    if ({ID_INSTR, ID_PC, ID_PC_4, ID_VALID} !== {32'hB0B0_0004, 32'h4, 32'h8, 1'b1}) begin
      errors++;
      $display("FAIL stall_release got %h/%h/%h/%b want b0b00004/4/8/1", ID_INSTR, ID_PC, ID_PC_4, ID_VALID);
    end
    cycle(1'b0, 1'b1, 1'b0, 32'h8, 32'hCCCC_0003);
    checks++;
    if ({ID_INSTR, ID_PC, ID_VALID} !== {32'hCCCC_0003, 32'h8, 1'b1}) begin
      errors++;
      $display("FAIL stall_after got %h/%h/%b want cccc0003/8/1", ID_INSTR, ID_PC, ID_VALID);
    end
  endtask

  task automatic test_flush();
    cycle(1'b0, 1'b1, 1'b0, 32'h0, 32'hAAAA_0001);
    cycle(1'b0, 1'b1, 1'b0, 32'h4, 32'hBBBB_0002);
    cycle(1'b0, 1'b1, 1'b1, 32'h8, 32'hCCCC_0003);
    checks++;
    if (DSLOT) begin
      if ({ID_INSTR, ID_PC, ID_VALID} !== {32'hCCCC_0003, 32'h8, 1'b1}) begin
        errors++;
        $display("FAIL flush_slot0 got %h/%h/%b want cccc0003/8/1", ID_INSTR, ID_PC, ID_VALID);
      end
    end else if ({ID_INSTR, ID_PC, ID_VALID} !== {32'h0, 32'h8, 1'b0}) begin
      errors++;
      $display("FAIL flush_slot0 got %h/%h/%b want 0/8/0", ID_INSTR, ID_PC, ID_VALID);
    end
    cycle(1'b0, 1'b1, 1'b0, 32'hC, 32'hDDDD_0004);
    checks++;
    if ({ID_INSTR, ID_PC, ID_VALID} !== {32'h0, 32'hC, 1'b0}) begin
      errors++;
      $display("FAIL flush_slot1 got %h/%h/%b want 0/c/0", ID_INSTR, ID_PC, ID_VALID);
    end
    cycle(1'b0, 1'b1, 1'b0, 32'h100, 32'h7A46_0100);
    checks++;
    if ({ID_INSTR, ID_PC, ID_PC_4, ID_VALID} !== {32'h7A46_0100, 32'h100, 32'h104, 1'b1}) begin
      errors++;
      $display("FAIL flush_target got %h/%h/%h/%b want 7a460100/100/104/1", ID_INSTR, ID_PC, ID_PC_4, ID_VALID);
    end
  endtask

  task automatic test_flush_stall();
    cycle(1'b0, 1'b1, 1'b0, 32'h300, 32'hAAAA_0300);
    cycle(1'b0, 1'b0, 1'b0, 32'h304, 32'hBBBB_0304);
    cycle(1'b0, 1'b0, 1'b1, 32'h304, 32'h5858_5858);
    checks++;
    if ({ID_INSTR, ID_PC, ID_VALID} !== {32'hAAAA_0300, 32'h300, 1'b1}) begin
      errors++;
      $display("FAIL flush_stall_hold got %h/%h/%b want aaaa0300/300/1", ID_INSTR, ID_PC, ID_VALID);
    end
    cycle(1'b0, 1'b1, 1'b0, 32'h200, 32'h7A46_0200);
    checks++;
    if ({ID_INSTR, ID_PC, ID_VALID} !== {32'h0, 32'h200, 1'b0}) begin
      errors++;
      $display("FAIL flush_stall_bubble got %h/%h/%b want 0/200/0", ID_INSTR, ID_PC, ID_VALID);
    end
    cycle(1'b0, 1'b1, 1'b0, 32'h204, 32'h7A46_0204);
    checks++;
    if ({ID_INSTR, ID_PC, ID_VALID} !== {32'h7A46_0204, 32'h204, 1'b1}) begin
      errors++;
      $display("FAIL flush_stall_target got %h/%h/%b want 7a460204/204/1", ID_INSTR, ID_PC, ID_VALID);
    end
  endtask

  task automatic test_wrap();
    cycle(1'b0, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'h1234_5678);
    checks++;
    if (PC_4 !== 32'h0) begin
      errors++;
      $display("FAIL wrap_pc4 got %h want 0", PC_4);
    end
    checks++;
    if ({ID_INSTR, ID_PC, ID_PC_4, ID_VALID} !== {32'h1234_5678, 32'hFFFF_FFFC, 32'h0, 1'b1}) begin
      errors++;
      $display("FAIL wrap_id got %h/%h/%h/%b want 12345678/fffffffc/0/1", ID_INSTR, ID_PC, ID_PC_4, ID_VALID);
    end
  endtask

  task automatic test_reset_mid();
    cycle(1'b0, 1'b1, 1'b1, 32'h400, 32'h1111_1111);
    cycle(1'b0, 1'b0, 1'b0, 32'h404, 32'h2222_2222);
    cycle(1'b1, 1'b1, 1'b0, 32'h404, 32'h3333_3333);
    checks++;
    if ({ID_INSTR, ID_PC, ID_PC_4, ID_VALID} !== {32'h0, 32'h0, 32'h0, 1'b0}) begin
      errors++;
      $display("FAIL reset_mid got %h/%h/%h/%b want 0/0/0/0", ID_INSTR, ID_PC, ID_PC_4, ID_VALID);
    end
    cycle(1'b0, 1'b1, 1'b0, 32'h500, 32'h4444_4444);
    checks++;
    if ({ID_INSTR, ID_PC, ID_VALID} !== {32'h4444_4444, 32'h500, 1'b1}) begin
      errors++;
      $display("FAIL reset_mid_after got %h/%h/%b want 44444444/500/1", ID_INSTR, ID_PC, ID_VALID);
    end
  endtask

  task automatic test_random();
    logic        rst, en, fl;
    logic [31:0] pc, dout;
    for (int i = 0; i < 600; i++) begin
      rst  = ($urandom_range(0, 49) == 0);
      en   = ($urandom_range(0, 9) < 7);
      fl   = ($urandom_range(0, 9) == 0);
      pc   = {$urandom(), 2'b00} & 32'hFFFF_FFFC;
      if ($urandom_range(0, 19) == 0) pc = 32'hFFFF_FFFC;
      dout = $urandom();
      cycle(rst, en, fl, pc, dout);
      checks++;
      if ({ID_INSTR, ID_PC, ID_PC_4, ID_VALID} !== {m_instr, m_pc, m_pc4, m_valid}) begin
        errors++;
        $display("FAIL random[%0d] got %h/%h/%h/%b want %h/%h/%h/%b", i, ID_INSTR, ID_PC, ID_PC_4,
                 ID_VALID, m_instr, m_pc, m_pc4, m_valid);
      end
      checks++;
      if (PC_4 !== pc + 32'd4) begin
        errors++;
        $display("FAIL random_pc4[%0d] got %h want %h", i, PC_4, pc + 32'd4);
      end
    end
  endtask

  initial begin
    RST = 1'b1; EN = 1'b0; flush = 1'b0; PC_IF = 32'h0; IMEM_DOUT = 32'hDEAD_BEEF;
    m_kill_left = 0;
    test_reset();
    test_straight();
    test_stall_replay();
    test_flush();
    test_flush_stall();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_id_stage.md
# if_id_stage

Fetch-to-decode pipeline stage of the MIPS150 core. Sits directly downstream of the program counter: takes the current fetch PC and the synchronous IMEM read data, and registers them into the IF/ID pipeline register consumed by decode. It also produces PC+4 back to the PC. It squashes wrong-path fetches after a redirect and replays the IMEM word lost when a stall starts.

## Interface
Parameters:
- FLUSH_DEPTH, 2: number of advancing cycles squashed after a flush pulse (1..3).
- NOP_WORD, 32'h0000_0000: instruction inserted for squashed slots (sll $0,$0,0).

Ports:
- CLK  in  1  clock, all state on posedge.
- RST  in  1  reset, synchronous, active-high.
- EN  in  1  pipeline advance; 0 = stall (IF/ID holds).
- flush  in  1  single-cycle redirect pulse from branch/jump resolution.
- PC_IF  in  32  PC of the word currently on IMEM_DOUT.
- IMEM_DOUT  in  32  synchronous IMEM read data, aligned with PC_IF.
- PC_4  out  32  PC_IF + 4, combinational, fed back to the PC.
- ID_INSTR  out  32  registered instruction to decode.
- ID_PC  out  32  registered PC of ID_INSTR.
- ID_PC_4  out  32  registered ID_PC + 4 (link value for JAL).
- ID_VALID  out  1  1 = real instruction; 0 = bubble.

## Operation
- Internal state: hold_valid, hold_instr[31:0], squash_cnt[1:0].
- Fetched word: f_instr = hold_valid ? hold_instr : IMEM_DOUT.
- Squash condition: squash = flush | (squash_cnt != 0).
- Skid hold: IMEM address moves even while PC_IF is held, so the first stall cycle must capture the word.
  - Edge with EN=0, hold_valid=0, flush=0: hold_instr <= IMEM_DOUT, hold_valid <= 1.
  - Edge with EN=0, hold_valid=1: no change.
  - Edge with EN=1 or flush=1: hold_valid <= 0.
- IF/ID register:
  - Edge with EN=1: ID_PC <= PC_IF, ID_PC_4 <= PC_IF+4.
  - Same edge, squash=0: ID_INSTR <= f_instr, ID_VALID <= 1.
  - Same edge, squash=1: ID_INSTR <= NOP_WORD, ID_VALID <= 0.
  - Edge with EN=0: all ID_* hold.
- Squash counter:
  - flush=1: squash_cnt <= FLUSH_DEPTH-1. Load wins over decrement.
  - Otherwise, EN=1 and squash_cnt != 0: squash_cnt decrements.
  - EN=0 freezes the counter.
- Arithmetic: all +4 adds are 32-bit modulo. 32'hFFFF_FFFC + 4 = 0, no flag.

## Timing
- Reset values: ID_INSTR=NOP_WORD, ID_PC=0, ID_PC_4=0, ID_VALID=0, hold_valid=0, squash_cnt=0.
- RST overrides EN and flush in the same cycle. RST mid-stall or mid-squash clears everything.
- Latency: IMEM_DOUT/PC_IF to ID_* is 1 edge when EN=1.
- Stall of N cycles, then release: the ID register loads the held word on the release edge. No word is lost or duplicated.
- Flush during stall (EN=0, flush=1): hold is discarded and the counter is loaded. The ID register holds. The squash window starts at the next EN=1 edge.
- flush while squash_cnt != 0: the counter reloads, extending the window.
- PC_4 has no registered delay.

## Configuration
- IF_DELAY_SLOT_EN:
  - Defined: squash = (squash_cnt != 0) only. The word fetched in the flush cycle (delay slot) enters ID as valid. Squash window is FLUSH_DEPTH-1 slots after it.
  - Undefined: behaviour as above; the flush-cycle word is squashed.

## Structure
- Shared package mips150_pkg holds:
  - NOP_WORD constant and 32-bit word width.
  - FLUSH_DEPTH default.
  - typedef if_id_t {instr, pc, pc_4, valid}.
- Sub-module fetch_skid_buf holds hold_valid/hold_instr and the f_instr mux. The rest is inline.

## Test plan
- Reset: assert RST 2 cycles with IMEM_DOUT=32'hDEADBEEF. Require ID_VALID=0, ID_INSTR=0, ID_PC=0 each cycle.
- Straight line: PC_IF=0,4,8 with words A,B,C and EN=1. Require ID_* = (A,0,4), (B,4,8), (C,8,12) one edge later each; PC_4 = PC_IF+4 combinationally.
- Stall replay: word B at PC 4, then EN=0 for 3 cycles while IMEM_DOUT changes to X,Y,Z, then EN=1. Require ID_INSTR=B, ID_PC=4 on the release edge; X/Y/Z never appear.
- Flush, FLUSH_DEPTH=2, macro off: flush pulse at PC 8. Require next 2 advancing slots ID_VALID=0, ID_INSTR=0, then target word valid.
- Flush, macro on: same stimulus. Require word at PC 8 valid, then 1 bubble, then target.
- Simultaneous flush+stall: EN=0 with hold full, flush=1, then EN=1. Require hold discarded and bubbles per FLUSH_DEPTH. Wrap: PC_IF=32'hFFFF_FFFC requires PC_4=0.
